// File: rtl/cache_pkg.sv
// Shared sizing parameters, controller state encoding and counter helper
// for the direct-mapped cache controller.
package cache_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int BLOCK_SIZE   = 128;
    localparam int TAG_WIDTH    = 24;
    localparam int INDEX_WIDTH  = 6;
    localparam int OFFSET_WIDTH = 2;
    localparam int ADDR_WIDTH   = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;
    localparam int STAT_WIDTH   = 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOOKUP     = 3'd1,
        S_COMPARE    = 3'd2,
        S_WRITE_BACK = 3'd3,
        S_ALLOCATE   = 3'd4,
        S_REFILL     = 3'd5,
        S_DONE       = 3'd6
    } cache_state_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        if (&value) begin
            return value;
        end else begin
            return value + STAT_WIDTH'(1);
        end
    endfunction

endpackage

// File: rtl/dm_cache_controller.sv
// Direct-mapped cache control FSM: lookup, dirty write-back, refill and
// re-lookup for one CPU request at a time, with saturating statistics.
module dm_cache_controller
    import cache_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_valid,
    input  logic                    cpu_req_type,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [WORD_SIZE-1:0]    cpu_wdata,
    output logic                    cpu_ready,
    output logic                    cpu_done,
    output logic [WORD_SIZE-1:0]    cpu_rdata,
    output logic [TAG_WIDTH-1:0]    tag,
    output logic [INDEX_WIDTH-1:0]  index,
    output logic [OFFSET_WIDTH-1:0] blk_offset,
    output logic                    req_type,
    output logic                    read_en_cache,
    output logic                    write_en_cache,
    output logic                    refill,
    output logic [WORD_SIZE-1:0]    data_in,
    input  logic                    hit,
    input  logic                    dirty_bit,
    input  logic [WORD_SIZE-1:0]    data_out,
    input  logic [TAG_WIDTH-1:0]    victim_tag,
    output logic                    mem_read_req,
    output logic                    mem_write_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_ack,
    output logic [STAT_WIDTH-1:0]   hit_cnt,
    output logic [STAT_WIDTH-1:0]   miss_cnt,
    output logic [STAT_WIDTH-1:0]   wb_cnt
);

    cache_state_t            state_r;
    cache_state_t            next_state_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    type_r;
    logic [WORD_SIZE-1:0]    wdata_r;
    logic                    relookup_r;

    logic                    ready_s;
    logic                    done_s;
    logic [WORD_SIZE-1:0]    rdata_s;
    logic                    rd_en_s;
    logic                    wr_en_s;
    logic                    refill_s;
    logic                    mem_rd_s;
    logic                    mem_wr_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_s;
    logic                    cur_type_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    next_state_s = S_LOOKUP;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_LOOKUP:  next_state_s = S_COMPARE;
            S_COMPARE: begin
                if (hit) begin
                    next_state_s = S_DONE;
                end else if (dirty_bit) begin
                    next_state_s = S_WRITE_BACK;
                end else begin
                    next_state_s = S_ALLOCATE;
                end
            end
            S_WRITE_BACK: begin
                if (mem_ack) begin
                    next_state_s = S_ALLOCATE;
                end else begin
                    next_state_s = S_WRITE_BACK;
                end
            end
            S_ALLOCATE: begin
                if (mem_ack) begin
                    next_state_s = S_REFILL;
                end else begin
                    next_state_s = S_ALLOCATE;
                end
            end
            S_REFILL: next_state_s = S_LOOKUP;
            S_DONE:   next_state_s = S_IDLE;
            default:  next_state_s = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register cleanly;
    // on the accepting edge the request type comes straight from the CPU port.
    always_comb begin
        cur_type_s = (state_r == S_IDLE) ? cpu_req_type : type_r;
        ready_s    = (next_state_s == S_IDLE);
        done_s     = (next_state_s == S_DONE);
        rd_en_s    = (next_state_s == S_LOOKUP) && !cur_type_s;
        wr_en_s    = ((next_state_s == S_LOOKUP) && cur_type_s) || (next_state_s == S_REFILL);
        refill_s   = (next_state_s == S_REFILL);
        mem_wr_s   = (next_state_s == S_WRITE_BACK);
        mem_rd_s   = (next_state_s == S_ALLOCATE);
        if ((next_state_s == S_DONE) && !type_r) begin
            rdata_s = data_out;
        end else begin
            rdata_s = {WORD_SIZE{1'b0}};
        end
        case (next_state_s)
            S_WRITE_BACK: mem_addr_s = {victim_tag, addr_r[OFFSET_WIDTH +: INDEX_WIDTH], {OFFSET_WIDTH{1'b0}}};
            S_ALLOCATE:   mem_addr_s = {addr_r[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            default:      mem_addr_s = {ADDR_WIDTH{1'b0}};
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ready      <= 1'b1;
            cpu_done       <= 1'b0;
            cpu_rdata      <= {WORD_SIZE{1'b0}};
            read_en_cache  <= 1'b0;
            write_en_cache <= 1'b0;
            refill         <= 1'b0;
            mem_read_req   <= 1'b0;
            mem_write_req  <= 1'b0;
            mem_addr       <= {ADDR_WIDTH{1'b0}};
        end else begin
            cpu_ready      <= ready_s;
            cpu_done       <= done_s;
            cpu_rdata      <= rdata_s;
            read_en_cache  <= rd_en_s;
            write_en_cache <= wr_en_s;
            refill         <= refill_s;
            mem_read_req   <= mem_rd_s;
            mem_write_req  <= mem_wr_s;
            mem_addr       <= mem_addr_s;
        end
    end

    // Request latch and re-lookup marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= {ADDR_WIDTH{1'b0}};
            type_r     <= 1'b0;
            wdata_r    <= {WORD_SIZE{1'b0}};
            relookup_r <= 1'b0;
        end else begin
            if ((state_r == S_IDLE) && cpu_req_valid) begin
                addr_r  <= cpu_addr;
                type_r  <= cpu_req_type;
                wdata_r <= cpu_wdata;
            end else begin
                addr_r  <= addr_r;
                type_r  <= type_r;
                wdata_r <= wdata_r;
            end
            if (state_r == S_REFILL) begin
                relookup_r <= 1'b1;
            end else if (state_r == S_IDLE) begin
                relookup_r <= 1'b0;
            end else begin
                relookup_r <= relookup_r;
            end
        end
    end

    assign tag        = addr_r[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign index      = addr_r[OFFSET_WIDTH +: INDEX_WIDTH];
    assign blk_offset = addr_r[OFFSET_WIDTH-1:0];
    assign req_type   = type_r;
    assign data_in    = wdata_r;

    // Statistics: only the first comparison of a request is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= {STAT_WIDTH{1'b0}};
            miss_cnt <= {STAT_WIDTH{1'b0}};
            wb_cnt   <= {STAT_WIDTH{1'b0}};
        end else if ((state_r == S_COMPARE) && !relookup_r) begin
            if (hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end else begin
                miss_cnt <= sat_inc(miss_cnt);
                if (dirty_bit) begin
                    wb_cnt <= sat_inc(wb_cnt);
                end else begin
                    wb_cnt <= wb_cnt;
                end
            end
        end else begin
            hit_cnt  <= hit_cnt;
            miss_cnt <= miss_cnt;
            wb_cnt   <= wb_cnt;
        end
    end

endmodule

// File: tb/tb_dm_cache_controller.sv
// Directed bench: controller plus behavioural direct-mapped cache array and
// a block memory that acknowledges three cycles after a request is seen.
module tb_dm_cache_controller;
    import cache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    cpu_req_valid = 1'b0;
    logic                    cpu_req_type = 1'b0;
    logic [ADDR_WIDTH-1:0]   cpu_addr = 32'h0;
    logic [WORD_SIZE-1:0]    cpu_wdata = 32'h0;
    logic                    cpu_ready, cpu_done;
    logic [WORD_SIZE-1:0]    cpu_rdata;
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] blk_offset;
    logic                    req_type, read_en_cache, write_en_cache, refill;
    logic [WORD_SIZE-1:0]    data_in;
    logic                    hit, dirty_bit;
    logic [WORD_SIZE-1:0]    data_out;
    logic [TAG_WIDTH-1:0]    victim_tag;
    logic                    mem_read_req, mem_write_req;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_ack;
    logic [STAT_WIDTH-1:0]   hit_cnt, miss_cnt, wb_cnt;

    dm_cache_controller dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_type(cpu_req_type),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .tag(tag), .index(index), .blk_offset(blk_offset), .req_type(req_type),
        .read_en_cache(read_en_cache), .write_en_cache(write_en_cache),
        .refill(refill), .data_in(data_in),
        .hit(hit), .dirty_bit(dirty_bit), .data_out(data_out), .victim_tag(victim_tag),
        .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    // Behavioural cache array.
    logic         c_valid [64];
    logic         c_dirty [64];
    logic [23:0]  c_tag   [64];
    logic [127:0] c_blk   [64];
    logic         pl_en = 1'b0;
    logic         pl_dirty = 1'b0;
    logic [5:0]   pl_idx = 6'd0;
    logic [23:0]  pl_tag = 24'h0;
    logic [127:0] pl_blk = 128'h0;

    // Behavioural memory: last written-back block plus a fixed pattern.
    logic         wb_valid;
    logic [31:0]  wb_addr_r;
    logic [127:0] wb_blk_r;
    logic [1:0]   mcnt;

    function automatic logic [31:0] pat(input logic [31:0] ba, input int w);
        return (ba ^ 32'h5A5A5A5A) + 32'(w);
    endfunction

    function automatic logic [127:0] mem_block(input logic [31:0] ba);
        if (wb_valid && (ba == wb_addr_r)) return wb_blk_r;
        return {pat(ba, 3), pat(ba, 2), pat(ba, 1), pat(ba, 0)};
    endfunction

    assign hit        = c_valid[index] && (c_tag[index] == tag);
    assign dirty_bit  = c_valid[index] && c_dirty[index];
    assign data_out   = c_blk[index][{blk_offset, 5'b00000} +: 32];
    assign victim_tag = c_tag[index];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                c_valid[i] <= 1'b0;
                c_dirty[i] <= 1'b0;
                c_tag[i]   <= 24'h0;
                c_blk[i]   <= 128'h0;
            end
        end else if (pl_en) begin
            c_valid[pl_idx] <= 1'b1;
            c_dirty[pl_idx] <= pl_dirty;
            c_tag[pl_idx]   <= pl_tag;
            c_blk[pl_idx]   <= pl_blk;
        end else if (refill) begin
            c_valid[index] <= 1'b1;
            c_dirty[index] <= 1'b0;
            c_tag[index]   <= tag;
            c_blk[index]   <= mem_block({tag, index, 2'b00});
        end else if (write_en_cache && hit) begin
            c_blk[index][{blk_offset, 5'b00000} +: 32] <= data_in;
            c_dirty[index] <= 1'b1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt     <= 2'd0;
            mem_ack  <= 1'b0;
            wb_valid <= 1'b0;
            wb_addr_r <= 32'h0;
            wb_blk_r <= 128'h0;
        end else if (mem_ack) begin
            mem_ack <= 1'b0;
        end else if (mem_read_req || mem_write_req) begin
            if (mcnt == 2'd2) begin
                mcnt    <= 2'd0;
                mem_ack <= 1'b1;
                if (mem_write_req) begin
                    wb_valid  <= 1'b1;
                    wb_addr_r <= mem_addr;
                    wb_blk_r  <= c_blk[mem_addr[7:2]];
                end
            end else begin
                mcnt <= mcnt + 2'd1;
            end
        end
    end

    // Request monitor: rising-edge counts and overlap detection.
    int   rd_reqs = 0, wr_reqs = 0;
    logic both_seen = 1'b0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    always @(posedge clk) begin
        prev_rd <= mem_read_req;
        prev_wr <= mem_write_req;
        if (mem_read_req && !prev_rd) rd_reqs <= rd_reqs + 1;
        if (mem_write_req && !prev_wr) wr_reqs <= wr_reqs + 1;
        if (mem_read_req && mem_write_req) both_seen <= 1'b1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [23:0] t, input logic d, input logic [127:0] b);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_tag = t; pl_dirty = d; pl_blk = b;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic t, input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd);
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_type = t; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        lat = 0;
        rd  = 32'h0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (cpu_done) begin
                lat = i;
                rd  = cpu_rdata;
                break;
            end
        end
    endtask

    int          lat, rd0, wr0;
    logic [31:0] rd;
    logic [31:0] ba;
    logic [127:0] old_blk;
    bit          seen;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", cpu_ready, 1'b1);
        check("reset_done", cpu_done, 1'b0);
        check("reset_memreq", {mem_read_req, mem_write_req}, 2'b00);
        check("reset_cnts", {hit_cnt, miss_cnt, wb_cnt}, 48'h0);
        rst_n = 1'b1;

        // Read hit
        preload(6'd0, 24'hABCDE0, 1'b0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111});
        rd0 = rd_reqs; wr0 = wr_reqs;
        issue(1'b0, {24'hABCDE0, 6'd0, 2'd3}, 32'h0, lat, rd);
        check("rhit_lat", lat, 3);
        check("rhit_rdata", rd, 32'h44444444);
        check("rhit_nomem", (rd_reqs - rd0) + (wr_reqs - wr0), 0);
        check("rhit_cnt", hit_cnt, 16'd1);

        // Write hit
        preload(6'd1, 24'h000ABC, 1'b0, 128'h0);
        issue(1'b1, {24'h000ABC, 6'd1, 2'd3}, 32'hCAFEBABE, lat, rd);
        check("whit_lat", lat, 3);
        check("whit_rdata", rd, 32'h0);
        check("whit_dirty", c_dirty[1], 1'b1);
        check("whit_word", c_blk[1][127:96], 32'hCAFEBABE);
        check("whit_cnt", hit_cnt, 16'd2);

        // Clean read miss
        rd0 = rd_reqs; wr0 = wr_reqs;
        ba = {24'h123456, 6'd2, 2'd0};
        issue(1'b0, {24'h123456, 6'd2, 2'd0}, 32'h0, lat, rd);
        check("cmiss_lat", lat, 10);
        check("cmiss_rdata", rd, pat(ba, 0));
        check("cmiss_rdreq", rd_reqs - rd0, 1);
        check("cmiss_wrreq", wr_reqs - wr0, 0);
        check("cmiss_cnt", {hit_cnt, miss_cnt, wb_cnt}, {16'd2, 16'd1, 16'd0});

        // Dirty read miss
        old_blk = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
        preload(6'd3, 24'h000333, 1'b1, old_blk);
        rd0 = rd_reqs; wr0 = wr_reqs;
        ba = {24'h000777, 6'd3, 2'd0};
        issue(1'b0, {24'h000777, 6'd3, 2'd1}, 32'h0, lat, rd);
        check("dmiss_lat", lat, 14);
        check("dmiss_wbaddr", wb_addr_r, {24'h000333, 6'd3, 2'd0});
        check("dmiss_wbdata", wb_blk_r, old_blk);
        check("dmiss_rdata", rd, pat(ba, 1));
        check("dmiss_reqs", {32'(rd_reqs - rd0), 32'(wr_reqs - wr0)}, {32'd1, 32'd1});
        check("dmiss_cnt", {hit_cnt, miss_cnt, wb_cnt}, {16'd2, 16'd2, 16'd1});
        check("dmiss_clean", c_dirty[3], 1'b0);

        // Clean write miss
        issue(1'b1, {24'h000444, 6'd4, 2'd0}, 32'hCAFEBABE, lat, rd);
        check("wmiss_lat", lat, 10);
        check("wmiss_word", c_blk[4][31:0], 32'hCAFEBABE);
        check("wmiss_dirty", c_dirty[4], 1'b1);
        check("wmiss_tag", c_tag[4], 24'h000444);
        check("wmiss_cnt", {hit_cnt, miss_cnt, wb_cnt}, {16'd2, 16'd3, 16'd1});
        check("no_overlap", both_seen, 1'b0);

        // Reset while waiting in ALLOCATE
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_type = 1'b0; cpu_addr = {24'h000555, 6'd5, 2'd0};
        @(posedge clk);
        #1 cpu_req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read_req) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_reached_alloc", seen, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_memreq", mem_read_req, 1'b0);
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_cnts", {hit_cnt, miss_cnt, wb_cnt}, 48'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_idle", {cpu_ready, cpu_done, mem_read_req}, 3'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
